// File: rtl/z80_sys_pkg.sv
// Shared constants for the Z80 system slice.
// Register map, FSM encoding and vector helper.
package z80_sys_pkg;

  localparam logic [1:0] INTC_MASK     = 2'd0;
  localparam logic [1:0] INTC_EOI_PEND = 2'd1;
  localparam logic [1:0] INTC_ISR      = 2'd2;
  localparam logic [1:0] INTC_CTRL     = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [7:0] INTC_IO_BASE = 8'h04;

  // 8-bit vector arithmetic; wraps mod 256.
  function automatic logic [7:0] intc_vec(
    input logic [7:0] base,
    input logic [7:0] idx,
    input logic [7:0] stride
  );
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/z80_int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder.
// idx reads N when nothing is set.
module prio_enc #(
  parameter int N  = 4,
  parameter int IW = $clog2(N + 1)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan downward so the lowest set bit wins.
  always_comb begin
    idx   = IW'(N);
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/z80_int_ctrl.sv
// Prioritised, nesting interrupt controller
// for the Z80 INT_n pin with IM2-style vectors.
module z80_int_ctrl
  import z80_sys_pkg::*;
#(
  parameter int           NUM_SRC       = 4,
  parameter logic [7:0]   VECTOR_BASE   = 8'h60,
  parameter int           VECTOR_STRIDE = 2,
  parameter logic [7:0]   SPURIOUS_VEC  = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               m1_n,
  input  logic               iorq_n,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata,
  output logic               int_n,
  output logic               vec_oe,
  output logic [7:0]         vec_data,
  output logic [NUM_SRC-1:0] isr
);

  localparam int IW = $clog2(NUM_SRC + 1);
  localparam logic [7:0] STRIDE8 = 8'(VECTOR_STRIDE);

  logic [1:0]         state;
  logic [NUM_SRC-1:0] mask;
  logic               enable;
  logic [IW-1:0]      win;
  logic               spur;

  logic [NUM_SRC-1:0] pending;
  logic [IW-1:0]      pend_idx;
  logic               pend_valid;
  logic [IW-1:0]      top_isr;
  logic               isr_valid;
  logic               eligible;
  logic               ack_cyc;
  logic               ack_done;
  logic               eoi;
  logic [NUM_SRC-1:0] isr_clr;
  logic [NUM_SRC-1:0] isr_set;

  // Reads have no side effects; keep the qualifier
  // and spare write bits visible to lint.
  logic unused_ok;
  assign unused_ok = ^{reg_re, reg_wdata};

  assign pending = src_req & ~mask;

  prio_enc #(.N(NUM_SRC), .IW(IW)) u_pend_enc (
    .req   (pending),
    .idx   (pend_idx),
    .valid (pend_valid)
  );

  prio_enc #(.N(NUM_SRC), .IW(IW)) u_isr_enc (
    .req   (isr),
    .idx   (top_isr),
    .valid (isr_valid)
  );

  assign eligible = enable && pend_valid
                 && (pend_idx < top_isr);
  assign ack_cyc  = !m1_n && !iorq_n;
  assign ack_done = (state == ST_ACK) && iorq_n;
  assign eoi      = reg_we
                 && (reg_addr == INTC_EOI_PEND);

  // EOI retires the top in-service bit; a
  // completing ack marks its winner in service.
  always_comb begin
    isr_clr = '0;
    isr_set = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      isr_clr[i] = eoi && isr_valid
                && (top_isr == IW'(i));
      isr_set[i] = ack_done && !spur
                && (win == IW'(i));
    end
  end

  // Combinational register read mux.
  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      INTC_MASK:     reg_rdata = 8'(mask);
      INTC_EOI_PEND: reg_rdata = 8'(pending);
      INTC_ISR:      reg_rdata = 8'(isr);
      default:       reg_rdata = {7'd0, enable};
    endcase
  end

  // Software-written mask and global enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask   <= '1;
      enable <= 1'b0;
    end else if (reg_we) begin
      if (reg_addr == INTC_MASK)
        mask <= reg_wdata[NUM_SRC-1:0];
      if (reg_addr == INTC_CTRL)
        enable <= reg_wdata[0];
    end
  end

  // In-service bits: clear against old isr,
  // then set the acknowledged winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) isr <= '0;
    else       isr <= (isr & ~isr_clr) | isr_set;
  end

  // Request / acknowledge sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      int_n    <= 1'b1;
      vec_oe   <= 1'b0;
      vec_data <= 8'h00;
      win      <= '0;
      spur     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eligible) begin
            state <= ST_REQ;
            int_n <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ack_cyc) begin
            state  <= ST_ACK;
            vec_oe <= 1'b1;
            win    <= pend_idx;
            spur   <= !pend_valid;
            vec_data <= pend_valid
              ? intc_vec(VECTOR_BASE,
                         8'(pend_idx), STRIDE8)
              : SPURIOUS_VEC;
          end else if (!eligible) begin
            state <= ST_IDLE;
            int_n <= 1'b1;
          end
        end
        ST_ACK: begin
          if (iorq_n) begin
            state  <= ST_IDLE;
            vec_oe <= 1'b0;
            int_n  <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          vec_oe <= 1'b0;
          int_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed bench for z80_int_ctrl.
// Stimulus on negedge, checks after it.
module tb_z80_int_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] src_req = '0;
  logic       m1_n = 1'b1;
  logic       iorq_n = 1'b1;
  logic       reg_we = 1'b0;
  logic       reg_re = 1'b0;
  logic [1:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0;
  logic [7:0] reg_rdata;
  logic       int_n;
  logic       vec_oe;
  logic [7:0] vec_data;
  logic [3:0] isr;

  int total = 0;
  int bad = 0;

  z80_int_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .src_req   (src_req),
    .m1_n      (m1_n),
    .iorq_n    (iorq_n),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .int_n     (int_n),
    .vec_oe    (vec_oe),
    .vec_data  (vec_data),
    .isr       (isr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [7:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [1:0] a,
                    input logic [7:0] exp);
    reg_re   = 1'b1;
    reg_addr = a;
    #1;
    chk(tag, reg_rdata, exp);
    reg_re = 1'b0;
  endtask

  task automatic ack_start();
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    tick();
  endtask

  task automatic ack_end();
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick();
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    tick();
    chk("rst_int_n", 8'(int_n), 8'h01);
    chk("rst_vec_oe", 8'(vec_oe), 8'h00);
    chk("rst_vec", vec_data, 8'h00);
    chk("rst_isr", 8'(isr), 8'h00);
    rd("rst_mask", 2'd0, 8'h0F);
    rd("rst_ctrl", 2'd3, 8'h00);

    // single source 1
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h00);
    src_req = 4'b0010;
    #1 chk("s1_pre", 8'(int_n), 8'h01);
    tick();
    chk("s1_int", 8'(int_n), 8'h00);
    ack_start();
    chk("s1_oe", 8'(vec_oe), 8'h01);
    chk("s1_vec", vec_data, 8'h62);
    tick();
    chk("s1_oe2", 8'(vec_oe), 8'h01);
    src_req = 4'b0000;
    ack_end();
    chk("s1_oe_off", 8'(vec_oe), 8'h00);
    chk("s1_isr", 8'(isr), 8'h02);
    chk("s1_int_off", 8'(int_n), 8'h01);
    rd("s1_isr_rd", 2'd2, 8'h02);

    // nesting: lower prio blocked, higher nests
    src_req = 4'b0100;
    tick(2);
    chk("n_block", 8'(int_n), 8'h01);
    src_req = 4'b0101;
    tick();
    chk("n_int", 8'(int_n), 8'h00);
    ack_start();
    chk("n_vec", vec_data, 8'h60);
    src_req = 4'b0000;
    ack_end();
    chk("n_isr", 8'(isr), 8'h03);
    wr(2'd1, 8'h00);
    chk("n_eoi1", 8'(isr), 8'h02);
    wr(2'd1, 8'h00);
    chk("n_eoi2", 8'(isr), 8'h00);
    wr(2'd1, 8'h00);
    chk("n_eoi_nop", 8'(isr), 8'h00);

    // request dropped before ack
    src_req = 4'b1000;
    tick();
    chk("d_int", 8'(int_n), 8'h00);
    src_req = 4'b0000;
    tick();
    chk("d_int_off", 8'(int_n), 8'h01);
    chk("d_isr", 8'(isr), 8'h00);

    // dropped in the ack cycle: spurious
    src_req = 4'b1000;
    tick();
    src_req = 4'b0000;
    ack_start();
    chk("sp_oe", 8'(vec_oe), 8'h01);
    chk("sp_vec", vec_data, 8'hFF);
    ack_end();
    chk("sp_isr", 8'(isr), 8'h00);
    chk("sp_int", 8'(int_n), 8'h01);

    // two at once, priority then re-request
    src_req = 4'b0101;
    tick();
    ack_start();
    chk("p_vec0", vec_data, 8'h60);
    src_req = 4'b0100;
    ack_end();
    chk("p_isr0", 8'(isr), 8'h01);
    tick();
    chk("p_hold", 8'(int_n), 8'h01);
    wr(2'd1, 8'h00);
    chk("p_eoi", 8'(isr), 8'h00);
    tick();
    chk("p_int2", 8'(int_n), 8'h00);
    ack_start();
    chk("p_vec2", vec_data, 8'h64);
    src_req = 4'b0000;
    ack_end();
    chk("p_isr2", 8'(isr), 8'h04);

    // EOI coincident with ack completion
    src_req = 4'b0001;
    tick();
    ack_start();
    chk("c_vec", vec_data, 8'h60);
    src_req   = 4'b0000;
    reg_we    = 1'b1;
    reg_addr  = 2'd1;
    reg_wdata = 8'hA5;
    ack_end();
    reg_we = 1'b0;
    chk("c_isr", 8'(isr), 8'h01);
    wr(2'd1, 8'h00);
    chk("c_isr0", 8'(isr), 8'h00);

    // masked / disabled
    wr(2'd0, 8'h0F);
    src_req = 4'b1111;
    tick(2);
    chk("m_int", 8'(int_n), 8'h01);
    rd("m_pend", 2'd1, 8'h00);
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h00);
    tick(2);
    chk("e_int", 8'(int_n), 8'h01);
    rd("e_pend", 2'd1, 8'h0F);
    rd("e_mask", 2'd0, 8'h00);

    // async reset during ack
    wr(2'd3, 8'h01);
    tick();
    chk("r_int", 8'(int_n), 8'h00);
    ack_start();
    chk("r_oe", 8'(vec_oe), 8'h01);
    chk("r_vec", vec_data, 8'h60);
    #2 reset = 1'b1;
    #1;
    chk("r_oe_async", 8'(vec_oe), 8'h00);
    chk("r_int_async", 8'(int_n), 8'h01);
    chk("r_vec_async", vec_data, 8'h00);
    tick();
    reset   = 1'b0;
    m1_n    = 1'b1;
    iorq_n  = 1'b1;
    src_req = 4'b0000;
    tick();
    rd("r_mask", 2'd0, 8'h0F);
    rd("r_ctrl", 2'd3, 8'h00);
    rd("r_isr", 2'd2, 8'h00);
    chk("r_int_n", 8'(int_n), 8'h01);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
